uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : byte FIFO feeding an 8N1 UART transmitter (LSB first)
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DLY_W = $clog2(DELAY_FRAMES);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DLY_W-1:0] BIT_LAST   = DLY_W'(DELAY_FRAMES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [DLY_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic bit_end;

  // Output / status decode
  always_comb begin
    fifo_empty = (count_q == '0);
    in_ready   = (count_q != FULL_COUNT) && rst_n;
    busy       = (state_q != ST_IDLE) || !fifo_empty;
    uart_tx    = tx_q;
    fifo_count = count_q;
  end

  assign push    = in_valid && in_ready;
  assign bit_end = (tick_q == BIT_LAST);

  // Next-state logic for the transmitter; pop is raised whenever a new frame is loaded
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    if (state_q != ST_IDLE) begin
      tick_d = bit_end ? '0 : tick_q + DLY_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Chaining straight into the next start bit keeps frames gap-free
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is not reset; push is already gated by rst_n through in_ready
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : randomized self-checking bench for uart_tx_fifo
// Rev 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] in_data  = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic [4:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_err = 0;

  logic       wave[$];
  logic       exp_wave[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Reference line waveform of one 8N1 frame: start 0, data LSB first, stop 1
  function automatic void add_frame(input logic [7:0] b);
    for (int k = 0; k < 10*D; k++) begin
      int slot;
      slot = k / D;
      if (slot == 0)      exp_wave.push_back(1'b0);
      else if (slot == 9) exp_wave.push_back(1'b1);
      else                exp_wave.push_back(b[slot-1]);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial decoder: samples mid-bit, drops frames that overlap reset
  initial begin : monitor
    logic [7:0] b;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        aborted = 1'b0;
        repeat (D + D/2) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        b[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (D) begin
            @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
          end
          b[i] = uart_tx;
        end
        repeat (D) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          if (uart_tx !== 1'b1) frame_err++;
          rx_q.push_back(b);
        end
        repeat (D/2 - 1) @(negedge clk);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30*10*D) begin
      step();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    repeat (3) step();
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", in_ready); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL release_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_single();
    int  diffs;
    logic last_busy;
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_accept_tx: got %b want 1", uart_tx); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL single_accept_count: got %0d want 1", fifo_count); end
    wave.delete(); exp_wave.delete();
    add_frame(8'h55);
    for (int k = 0; k < 10*D; k++) begin
      step();
      wave.push_back(uart_tx);
    end
    last_busy = busy;
    diffs = 0;
    foreach (exp_wave[i]) if (wave[i] !== exp_wave[i]) diffs++;
    n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL single_wave: %0d cycles differ, want 0", diffs); end
    n_cmp++; if (last_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_stop: got %b want 1", last_busy); end
    step();
    n_cmp++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_after: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
    end
  endtask

  task automatic test_back_to_back();
    int diffs;
    in_data = 8'hA3; in_valid = 1'b1;
    step();
    in_data = 8'h0F;
    step();
    in_valid = 1'b0;
    wave.delete(); exp_wave.delete();
    add_frame(8'hA3);
    add_frame(8'h0F);
    wave.push_back(uart_tx);
    for (int k = 1; k < 20*D; k++) begin
      step();
      wave.push_back(uart_tx);
    end
    diffs = 0;
    foreach (exp_wave[i]) if (wave[i] !== exp_wave[i]) diffs++;
    n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL b2b_wave: %0d cycles differ, want 0", diffs); end
    step();
    n_cmp++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_after: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
    end
  endtask

  task automatic test_fill();
    int         accepted, waited, extra_ready, mism;
    logic [7:0] v;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      v = 8'($urandom);
      in_data = v; in_valid = 1'b1;
      // 16 slots plus the byte popped on the second edge
      if (c < DEPTH + 1) exp_q.push_back(v);
      if (in_ready === 1'b1) accepted++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (accepted != DEPTH + 1) begin n_bad++; $display("FAIL fill_accepted: got %0d want %0d", accepted, DEPTH + 1); end
    n_cmp++; if (fifo_count !== 5'd16) begin n_bad++; $display("FAIL fill_count: got %0d want 16", fifo_count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", in_ready); end
    // first frame ends 10*D edges after its pop on edge 1
    waited = 0;
    while (in_ready !== 1'b1 && waited < 60) begin
      step();
      waited++;
    end
    n_cmp++; if (waited != 10*D + 1 - 19) begin n_bad++; $display("FAIL fill_reopen: after %0d edges, want %0d", waited, 10*D + 1 - 19); end
    v = 8'($urandom);
    in_data = v; in_valid = 1'b1;
    exp_q.push_back(v);
    step();
    n_cmp++; if (fifo_count !== 5'd16) begin n_bad++; $display("FAIL fill_refill_count: got %0d want 16", fifo_count); end
    extra_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) extra_ready++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (extra_ready != 0) begin n_bad++; $display("FAIL fill_single_accept: %0d extra ready cycles, want 0", extra_ready); end
    wait_drain("fill");
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fill_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    mism = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    n_cmp++; if (mism != 0) begin n_bad++; $display("FAIL fill_rx_data: %0d bytes wrong, want 0", mism); end
  endtask

  task automatic test_simul_push_pop();
    int         mism;
    logic [7:0] v;
    rx_q.delete(); exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      v = 8'($urandom);
      in_data = v; in_valid = 1'b1;
      exp_q.push_back(v);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd3) begin n_bad++; $display("FAIL simul_pre_count: got %0d want 3", fifo_count); end
    repeat (10*D - 4 + 1) step();
    n_cmp++; if (fifo_count !== 5'd3 || uart_tx !== 1'b1) begin
      n_bad++; $display("FAIL simul_stop: count=%0d tx=%b want count=3 tx=1", fifo_count, uart_tx);
    end
    v = 8'($urandom);
    in_data = v; in_valid = 1'b1;
    exp_q.push_back(v);
    step();
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd3) begin n_bad++; $display("FAIL simul_count: got %0d want 3", fifo_count); end
    n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL simul_start: tx=%b want 0", uart_tx); end
    wait_drain("simul");
    mism = (rx_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    n_cmp++; if (mism != 0) begin n_bad++; $display("FAIL simul_order: %0d errors (got %0d bytes want %0d)", mism, rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    rx_q.delete();
    in_data = 8'h81; in_valid = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd5) begin n_bad++; $display("FAIL abort_queued: got %0d want 5", fifo_count); end
    repeat (17) step();
    n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL abort_bit4: tx=%b want 0", uart_tx); end
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    step();
    n_cmp++; if (uart_tx !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: tx=%b count=%0d busy=%b ready=%b want 1/0/0/0", uart_tx, fifo_count, busy, in_ready);
    end
    step();
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL abort_reject: count=%0d want 0", fifo_count); end
    rst_n = 1'b1; in_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 15*D; c++) begin
      step();
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_quiet: %0d active cycles after release, want 0", bad); end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL abort_no_resume: %0d frames decoded, want 0", rx_q.size()); end
  endtask

  task automatic test_random();
    int acc, cyc, bad_ready, mism;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
    acc = 0; cyc = 0; bad_ready = 0;
    while (acc < 20 && cyc < 3000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if (in_ready !== (fifo_count != 5'd16) || fifo_count > 5'd16) bad_ready++;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(in_data);
        acc++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (acc != 20) begin n_bad++; $display("FAIL rand_accepted: got %0d want 20", acc); end
    n_cmp++; if (bad_ready != 0) begin n_bad++; $display("FAIL rand_ready: %0d bad cycles, want 0", bad_ready); end
    wait_drain("rand");
    mism = (rx_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    n_cmp++; if (mism != 0) begin n_bad++; $display("FAIL rand_stream: %0d errors (got %0d bytes want %0d)", mism, rx_q.size(), exp_q.size()); end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL rand_framing: %0d bad stop bits, want 0", frame_err); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_simul_push_pop();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
